// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//  Shared types and defaults for the unified-memory port arbiter.
//  Contents:
//   arb_state_e            arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   grant_e                owner of the most recent grant (GNT_IF, GNT_MEM)
//   MEMARB_DEAD_WORD       read data returned on an abandoned transfer
//   MEMARB_TIMEOUT_CYCLES  default bus_ready wait limit (used with MEMARB_TIMEOUT_EN)
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

    localparam logic [31:0] MEMARB_DEAD_WORD      = 32'hDEAD_BEEF;
    localparam int          MEMARB_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//  Bundles the three sides of the arbiter: the IF-stage fetch port, the
//  MEM-stage load/store port and the shared memory bus.
//  Modports:
//   master  the arbiter itself (it masters the memory bus and answers both stages)
//   slave   the surroundings: pipeline stages plus the memory
//  Signals:
//   if_req/if_addr/if_abort -> if_ack/if_rdata/if_stall
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata -> mem_ack/mem_rdata/mem_stall
//   bus_req/bus_we/bus_be/bus_addr/bus_wdata <- bus_rdata/bus_ready
//   timeout_err  sticky abandoned-transfer flag
interface mem_port_arbiter_if;

    logic        if_req;
    logic [29:0] if_addr;
    logic        if_abort;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_stall;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_stall;

    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    logic        timeout_err;

    modport master (
        input  if_req, if_addr, if_abort,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  bus_rdata, bus_ready,
        output if_ack, if_rdata, if_stall,
        output mem_ack, mem_rdata, mem_stall,
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output timeout_err
    );

    modport slave (
        output if_req, if_addr, if_abort,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output bus_rdata, bus_ready,
        input  if_ack, if_rdata, if_stall,
        input  mem_ack, mem_rdata, mem_stall,
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  timeout_err
    );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// mem_port_arbiter_watchdog
//  Bus-transfer watchdog: a down-counter reloaded on every grant and
//  decremented while a transfer is outstanding; expired is raised in the
//  TIMEOUT_CYCLES-th busy cycle without completion.
//  Only built when MEMARB_TIMEOUT_EN is defined.
//  Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   load     in  grant this cycle: reload the counter
//   run      in  a transfer is outstanding
//   expired  out terminal count reached while running
`ifdef MEMARB_TIMEOUT_EN
module mem_port_arbiter_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int               CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= TC_LOAD;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = run && (cnt_q == '0);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//  Shares one single-ported memory between instruction fetch (IF) and
//  load/store (MEM). One bus transfer at a time, round-robin on ties,
//  one-cycle ack pulse per completed request, per-stage stall outputs.
//  Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   port  mem_port_arbiter_if.master (fetch port, data port, memory bus,
//         timeout_err)
//  Parameters:
//   TIMEOUT_CYCLES  bus_ready wait limit before abandoning a transfer
//   DEAD_WORD       read data returned on an abandoned transfer
//  Build option:
//   MEMARB_TIMEOUT_EN  when defined, a watchdog abandons transfers that see no
//                      bus_ready for TIMEOUT_CYCLES cycles and sets timeout_err;
//                      when undefined the arbiter waits forever and
//                      timeout_err stays 0.
//
//  state  | meaning
//  IDLE   | no transfer on the bus; grant decision made here
//  BUSY_I | fetch transfer outstanding on the bus
//  BUSY_D | load/store transfer outstanding on the bus
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = MEMARB_TIMEOUT_CYCLES,
    parameter logic [31:0] DEAD_WORD      = MEMARB_DEAD_WORD
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master port
);

    arb_state_e  state_q, state_d;
    grant_e      last_q, last_d;
    logic        abort_q, abort_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [29:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        terr_q, terr_d;

    logic        grant;
    logic        wd_expired;
    logic        if_elig;
    logic        mem_elig;
    logic        pick_mem;
    logic        xfer_done;
    logic        abort_now;
    logic [31:0] rdata_in;

    // A requester whose ack is pulsing this cycle is still holding req high;
    // it must not be granted again off that stale request.
    assign if_elig   = port.if_req && !if_ack_q && !port.if_abort;
    assign mem_elig  = port.mem_req && !mem_ack_q;
    assign pick_mem  = mem_elig && (!if_elig || (last_q == GNT_IF));

    assign xfer_done = port.bus_ready || wd_expired;
    assign rdata_in  = port.bus_ready ? port.bus_rdata : DEAD_WORD;
    assign abort_now = abort_q || port.if_abort;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        abort_d     = abort_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        terr_d      = terr_q || (wd_expired && !port.bus_ready);
        grant       = 1'b0;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (pick_mem) begin
                    state_d     = BUSY_D;
                    last_d      = GNT_MEM;
                    grant       = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = port.mem_we;
                    bus_be_d    = port.mem_be;
                    bus_addr_d  = port.mem_addr;
                    bus_wdata_d = port.mem_wdata;
                end else if (if_elig) begin
                    state_d     = BUSY_I;
                    last_d      = GNT_IF;
                    grant       = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = 4'hF;
                    bus_addr_d  = port.if_addr;
                    bus_wdata_d = '0;
                end
            end

            BUSY_I: begin
                // A flushed fetch still runs to completion on the bus; only
                // the ack back to the pipeline is dropped.
                abort_d = abort_now;
                if (xfer_done) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    abort_d   = 1'b0;
                    if (!abort_now) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = rdata_in;
                    end
                end
            end

            BUSY_D: begin
                if (xfer_done) begin
                    state_d     = IDLE;
                    bus_req_d   = 1'b0;
                    mem_ack_d   = 1'b1;
                    mem_rdata_d = (bus_we_q && port.bus_ready) ? 32'h0 : rdata_in;
                end
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= GNT_IF;
            abort_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            abort_q     <= abort_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            terr_q      <= terr_d;
        end
    end

`ifdef MEMARB_TIMEOUT_EN
    mem_port_arbiter_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .load    (grant),
        .run     (state_q != IDLE),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    assign port.if_ack      = if_ack_q;
    assign port.if_rdata    = if_rdata_q;
    assign port.if_stall    = port.if_req && !if_ack_q;
    assign port.mem_ack     = mem_ack_q;
    assign port.mem_rdata   = mem_rdata_q;
    assign port.mem_stall   = port.mem_req && !mem_ack_q;
    assign port.bus_req     = bus_req_q;
    assign port.bus_we      = bus_we_q;
    assign port.bus_be      = bus_be_q;
    assign port.bus_addr    = bus_addr_q;
    assign port.bus_wdata   = bus_wdata_q;
    assign port.timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//  Directed scenarios (single fetch, tie-break order, stalled store, fetch
//  abort, reset mid-transfer, watchdog when MEMARB_TIMEOUT_EN is defined)
//  followed by a randomized run: two requesters with random addresses and
//  store data, a random-latency memory on the bus, and a reference memory
//  updated from the requests themselves.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if bif ();

`ifdef MEMARB_TIMEOUT_EN
    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .port(bif));
`else
    mem_port_arbiter dut (.clk(clk), .rst(rst), .port(bif));
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] bus_mem [logic [29:0]];
    logic [29:0] pool [8];

    logic        if_pend, mem_pend;
    logic [29:0] if_a, mem_a;
    logic        mem_w;
    logic [3:0]  mem_b;
    logic [31:0] mem_d;
    int          if_wait, mem_wait, busy_cnt, next_ack, n_req, n_ack;
    logic        p_req, p_rdy, p_we, rdy;
    logic [3:0]  p_be;
    logic [29:0] p_addr;
    logic [31:0] p_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return {a[15:0] ^ 16'h5A5A, a[29:14]};
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] peek_ref(input logic [29:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] peek_bus(input logic [29:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return init_word(a);
    endfunction

    initial begin
        pool = '{30'h0000_0010, 30'h3FFF_FFF0, 30'h1555_5555, 30'h2AAA_AAAA,
                 30'h0000_0040, 30'h0123_4567, 30'h3000_0001, 30'h0FF0_0FF0};
        rst = 1'b1;
        bif.if_req = 1'b0;  bif.if_addr = '0;  bif.if_abort = 1'b0;
        bif.mem_req = 1'b0; bif.mem_we = 1'b0; bif.mem_be = '0; bif.mem_addr = '0; bif.mem_wdata = '0;
        bif.bus_rdata = '0; bif.bus_ready = 1'b0;
        step(); step();

        // reset state
        chk("rst_bus_req",   32'(bif.bus_req), 32'd0);
        chk("rst_if_ack",    32'(bif.if_ack), 32'd0);
        chk("rst_mem_ack",   32'(bif.mem_ack), 32'd0);
        chk("rst_if_rdata",  bif.if_rdata, 32'd0);
        chk("rst_mem_rdata", bif.mem_rdata, 32'd0);
        chk("rst_bus_addr",  32'(bif.bus_addr), 32'd0);
        chk("rst_terr",      32'(bif.timeout_err), 32'd0);

        // single fetch, bus always ready
        rst = 1'b0;
        bif.if_req = 1'b1; bif.if_addr = 30'h10; bif.bus_ready = 1'b1; bif.bus_rdata = 32'h2402_0005;
        #1;
        chk("a_t0_if_stall", 32'(bif.if_stall), 32'd1);
        chk("a_t0_bus_req",  32'(bif.bus_req), 32'd0);
        step();
        chk("a_t1_bus_req",  32'(bif.bus_req), 32'd1);
        chk("a_t1_bus_addr", 32'(bif.bus_addr), 32'h10);
        chk("a_t1_bus_be",   32'(bif.bus_be), 32'hF);
        chk("a_t1_bus_we",   32'(bif.bus_we), 32'd0);
        chk("a_t1_if_stall", 32'(bif.if_stall), 32'd1);
        chk("a_t1_if_ack",   32'(bif.if_ack), 32'd0);
        step();
        chk("a_t2_if_ack",   32'(bif.if_ack), 32'd1);
        chk("a_t2_if_rdata", bif.if_rdata, 32'h2402_0005);
        chk("a_t2_if_stall", 32'(bif.if_stall), 32'd0);
        chk("a_t2_bus_req",  32'(bif.bus_req), 32'd0);
        bif.if_req = 1'b0;
        step();
        chk("a_t3_if_ack",   32'(bif.if_ack), 32'd0);

        // simultaneous requests after reset: MEM first, IF with no gap
        rst = 1'b1; step(); rst = 1'b0;
        bif.if_req = 1'b1; bif.if_addr = 30'h20;
        bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_addr = 30'h40; bif.mem_be = 4'hF;
        step();
        chk("b_t1_bus_req",  32'(bif.bus_req), 32'd1);
        chk("b_t1_bus_addr", 32'(bif.bus_addr), 32'h40);
        bif.bus_rdata = 32'h8C43_0000;
        step();
        chk("b_t2_mem_ack",   32'(bif.mem_ack), 32'd1);
        chk("b_t2_mem_rdata", bif.mem_rdata, 32'h8C43_0000);
        chk("b_t2_if_ack",    32'(bif.if_ack), 32'd0);
        chk("b_t2_if_stall",  32'(bif.if_stall), 32'd1);
        bif.mem_req = 1'b0;
        bif.bus_rdata = 32'h0800_0010;
        step();
        chk("b_t3_bus_req",  32'(bif.bus_req), 32'd1);
        chk("b_t3_bus_addr", 32'(bif.bus_addr), 32'h20);
        step();
        chk("b_t4_if_ack",   32'(bif.if_ack), 32'd1);
        chk("b_t4_if_rdata", bif.if_rdata, 32'h0800_0010);
        bif.if_req = 1'b0;
        step();

        // store with bus_ready held off for three cycles
        bif.mem_req = 1'b1; bif.mem_we = 1'b1; bif.mem_be = 4'b0011; bif.mem_addr = 30'h0A0;
        bif.mem_wdata = 32'hCAFE_F00D; bif.bus_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("c_bus_req",   32'(bif.bus_req), 32'd1);
            chk("c_bus_we",    32'(bif.bus_we), 32'd1);
            chk("c_bus_be",    32'(bif.bus_be), 32'h3);
            chk("c_bus_addr",  32'(bif.bus_addr), 32'h0A0);
            chk("c_bus_wdata", bif.bus_wdata, 32'hCAFE_F00D);
            chk("c_mem_stall", 32'(bif.mem_stall), 32'd1);
            bif.bus_ready = (k == 4);
        end
        step();
        chk("c_mem_ack",   32'(bif.mem_ack), 32'd1);
        chk("c_mem_rdata", bif.mem_rdata, 32'd0);
        chk("c_bus_req_0", 32'(bif.bus_req), 32'd0);
        bif.mem_req = 1'b0; bif.mem_we = 1'b0;
        step();

        // fetch aborted while on the bus, load right behind it
        bif.if_req = 1'b1; bif.if_addr = 30'h30; bif.bus_ready = 1'b0;
        step();
        chk("d_t1_bus_req",  32'(bif.bus_req), 32'd1);
        chk("d_t1_bus_addr", 32'(bif.bus_addr), 32'h30);
        bif.if_abort = 1'b1;
        step();
        chk("d_t2_bus_req",  32'(bif.bus_req), 32'd1);
        bif.if_abort = 1'b0; bif.if_req = 1'b0;
        bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_addr = 30'h50;
        bif.bus_ready = 1'b1; bif.bus_rdata = 32'h5555_AAAA;
        step();
        chk("d_t3_if_ack",   32'(bif.if_ack), 32'd0);
        chk("d_t3_if_rdata", bif.if_rdata, 32'h0800_0010);
        chk("d_t3_bus_req",  32'(bif.bus_req), 32'd0);
        bif.bus_rdata = 32'h1234_5678;
        step();
        chk("d_t4_bus_req",  32'(bif.bus_req), 32'd1);
        chk("d_t4_bus_addr", 32'(bif.bus_addr), 32'h50);
        chk("d_t4_if_ack",   32'(bif.if_ack), 32'd0);
        step();
        chk("d_t5_mem_ack",   32'(bif.mem_ack), 32'd1);
        chk("d_t5_mem_rdata", bif.mem_rdata, 32'h1234_5678);
        bif.mem_req = 1'b0;
        step();

        // reset while a transfer is on the bus
        bif.if_req = 1'b1; bif.if_addr = 30'h70; bif.bus_ready = 1'b0;
        step();
        chk("e_bus_req_pre", 32'(bif.bus_req), 32'd1);
        rst = 1'b1; bif.if_req = 1'b0; bif.bus_ready = 1'b1;
        step();
        chk("e_bus_req",   32'(bif.bus_req), 32'd0);
        chk("e_bus_addr",  32'(bif.bus_addr), 32'd0);
        chk("e_bus_ctl",   {27'd0, bif.bus_we, bif.bus_be}, 32'd0);
        chk("e_bus_wdata", bif.bus_wdata, 32'd0);
        chk("e_rdata",     bif.if_rdata | bif.mem_rdata, 32'd0);
        chk("e_acks",      {30'd0, bif.if_ack, bif.mem_ack}, 32'd0);
        rst = 1'b0;
        step();
        chk("e_post_ack",  32'(bif.if_ack), 32'd0);
        chk("e_post_req",  32'(bif.bus_req), 32'd0);

`ifdef MEMARB_TIMEOUT_EN
        // fetch that never sees bus_ready
        bif.if_req = 1'b1; bif.if_addr = 30'h44; bif.bus_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t_bus_req", 32'(bif.bus_req), 32'd1);
            chk("t_terr_0",  32'(bif.timeout_err), 32'd0);
        end
        step();
        chk("t_bus_req_0", 32'(bif.bus_req), 32'd0);
        chk("t_if_ack",    32'(bif.if_ack), 32'd1);
        chk("t_if_rdata",  bif.if_rdata, 32'hDEAD_BEEF);
        chk("t_terr",      32'(bif.timeout_err), 32'd1);
        bif.if_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t_terr_sticky", 32'(bif.timeout_err), 32'd1);
        end
        rst = 1'b1; step(); rst = 1'b0;
        chk("t_terr_rst", 32'(bif.timeout_err), 32'd0);
`endif

        // randomized traffic against the reference memory
        rst = 1'b1; step(); rst = 1'b0;
        if_pend = 1'b0; mem_pend = 1'b0; if_wait = 0; mem_wait = 0; busy_cnt = 0;
        next_ack = 0; n_req = 0; n_ack = 0;
        if_a = '0; mem_a = '0; mem_w = 1'b0; mem_b = '0; mem_d = '0;
        p_req = 1'b0; p_rdy = 1'b0; p_we = 1'b0; p_be = '0; p_addr = '0; p_wd = '0;
        bif.if_req = 1'b0; bif.mem_req = 1'b0; bif.bus_ready = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("r_dual_ack", 32'(bif.if_ack & bif.mem_ack), 32'd0);
            chk("r_if_ack_spurious",  32'(bif.if_ack & ~if_pend), 32'd0);
            chk("r_mem_ack_spurious", 32'(bif.mem_ack & ~mem_pend), 32'd0);
            if (p_req && !p_rdy) begin
                chk("r_bus_hold",   32'(bif.bus_req), 32'd1);
                chk("r_bus_addr_stable", 32'(bif.bus_addr), 32'(p_addr));
                chk("r_bus_ctl_stable",  {27'd0, bif.bus_we, bif.bus_be}, {27'd0, p_we, p_be});
                chk("r_bus_wdata_stable", bif.bus_wdata, p_wd);
            end
            if (bif.if_ack && if_pend) begin
                chk("r_if_rdata",   bif.if_rdata, peek_ref(if_a));
                chk("r_if_latency", 32'(if_wait >= 2), 32'd1);
                if (next_ack != 0) chk("r_fair_order", 32'd1, 32'(next_ack));
                next_ack = mem_pend ? 2 : 0;
                if_pend = 1'b0; n_ack++;
            end
            if (bif.mem_ack && mem_pend) begin
                if (mem_w) begin
                    chk("r_store_rdata", bif.mem_rdata, 32'd0);
                    ref_mem[mem_a] = merge_be(peek_ref(mem_a), mem_d, mem_b);
                end else begin
                    chk("r_load_rdata", bif.mem_rdata, peek_ref(mem_a));
                end
                chk("r_mem_latency", 32'(mem_wait >= 2), 32'd1);
                if (next_ack != 0) chk("r_fair_order", 32'd2, 32'(next_ack));
                next_ack = if_pend ? 1 : 0;
                mem_pend = 1'b0; n_ack++;
            end
            chk("r_if_wait_bound",  32'(if_pend && (if_wait > 40)), 32'd0);
            chk("r_mem_wait_bound", 32'(mem_pend && (mem_wait > 40)), 32'd0);

            if (!if_pend && (cyc < 2800) && ($urandom_range(0, 2) == 0)) begin
                if_pend = 1'b1; if_a = pool[$urandom_range(0, 7)]; if_wait = 0; n_req++;
            end
            if (!mem_pend && (cyc < 2800) && ($urandom_range(0, 2) == 0)) begin
                mem_pend = 1'b1; mem_a = pool[$urandom_range(0, 7)]; mem_wait = 0; n_req++;
                mem_w = 1'($urandom_range(0, 1)); mem_b = 4'($urandom_range(1, 15)); mem_d = $urandom;
            end
            bif.if_req    = if_pend;
            bif.if_addr   = if_pend ? if_a : 30'($urandom);
            bif.mem_req   = mem_pend;
            bif.mem_addr  = mem_pend ? mem_a : 30'($urandom);
            bif.mem_we    = mem_w;
            bif.mem_be    = mem_b;
            bif.mem_wdata = mem_d;

            if (bif.bus_req) begin
                busy_cnt++;
                rdy = ($urandom_range(0, 2) != 0) || (busy_cnt >= 4);
            end else begin
                busy_cnt = 0;
                rdy = 1'($urandom_range(0, 1));
            end
            bif.bus_ready = rdy;
            bif.bus_rdata = $urandom;
            if (bif.bus_req && rdy) begin
                if (bif.bus_we) bus_mem[bif.bus_addr] = merge_be(peek_bus(bif.bus_addr), bif.bus_wdata, bif.bus_be);
                else            bif.bus_rdata = peek_bus(bif.bus_addr);
            end
            p_req = bif.bus_req; p_rdy = rdy; p_we = bif.bus_we; p_be = bif.bus_be;
            p_addr = bif.bus_addr; p_wd = bif.bus_wdata;

            if (if_pend)  if_wait++;
            if (mem_pend) mem_wait++;
            step();
        end

        chk("r_drain_if",   32'(if_pend), 32'd0);
        chk("r_drain_mem",  32'(mem_pend), 32'd0);
        chk("r_ack_count",  32'(n_ack), 32'(n_req));
        chk("r_terr_clear", 32'(bif.timeout_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
